lsu_rv32: RTL
=============

LSU_RV32 -- requirements
Module: lsu_rv32

Interface
REQ-001 The block SHALL have these ports: clk  in  1  system clock, all state on rising edge.
REQ-002 The block SHALL have these ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have these ports: start  in  1  one-cycle request qualifying the inputs below.
REQ-004 The block SHALL have these ports: is_store  in  1  1 = store, 0 = load.
REQ-005 The block SHALL have these ports: funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 The block SHALL have these ports: addr  in  32  effective address from the upstream ALU result.
REQ-007 The block SHALL have these ports: wdata  in  32  store data (rs2).
REQ-008 The block SHALL have these ports: busy  out  1  high from the cycle after an accepted start until done.
REQ-009 The block SHALL have these ports: done  out  1  one-cycle completion pulse.
REQ-010 The block SHALL have these ports: err  out  1  valid with done; illegal funct3 or misaligned access.
REQ-011 The block SHALL have these ports: rdata  out  32  extended load result, valid with done.
REQ-012 The block SHALL have these ports: mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_be  out  4, mem_wdata  out  32  data-bus request.
REQ-013 The block SHALL have these ports: mem_ack  in  1, mem_rdata  in  32  data-bus response.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, REQ and DONE.
REQ-015 In IDLE, start SHALL latch is_store/funct3/addr/wdata, and the FSM SHALL go to REQ, or to DONE with err=1 when the access is illegal or misaligned.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 In REQ, mem_req SHALL be held at 1 with stable mem_* outputs until mem_ack=1 is sampled; the FSM SHALL then go to DONE.
REQ-018 mem_ack SHALL be ignored whenever mem_req=0.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a start in that cycle SHALL be ignored.
REQ-020 Latency SHALL be: start at cycle N gives mem_req from N+1; ack at cycle M gives done at M+1; minimum start-to-done is 2 cycles.
REQ-021 An error case SHALL give done at N+1 with no bus request.
REQ-022 mem_addr SHALL be {addr[31:2],2'b00}; mem_we SHALL equal is_store.
REQ-023 mem_be SHALL be: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<addr[1:0]; W 4'b1111.
REQ-024 mem_wdata SHALL be: B the byte replicated x4; H the halfword replicated x2; W wdata.
REQ-025 Loads SHALL capture mem_rdata on the ack cycle, select the lane given by addr[1:0], and sign-extend (B, H) or zero-extend (BU, HU).
REQ-026 Stores SHALL complete with rdata=0.
REQ-027 Illegal funct3 SHALL be 011, 110 and 111, plus 100/101 with is_store=1; each SHALL give err=1 and rdata=0.
REQ-028 rdata and err SHALL hold their values until the next done.
REQ-029 When not in REQ, mem_req SHALL be 0 and mem_be SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL immediately force the FSM to IDLE and busy, done, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata and rdata to 0.
REQ-031 A reset asserted mid-transaction SHALL drop mem_req asynchronously, produce no done, and leave any in-flight ack ignored.
REQ-032 Normal operation SHALL resume at the first clock edge after rst_n rises.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 and W with addr[1:0]!=0 SHALL be errors (err=1, no bus request, done at N+1).
REQ-034 Macro LSU_MISALIGN_TRAP_EN undefined: the low address bits SHALL be truncated to natural alignment (H uses addr[1]; W uses offset 0), the access SHALL proceed normally, and err SHALL flag only illegal funct3.

Verification
REQ-035 Load BU: addr=0x1003, mem_rdata=0x80FF_1234, ack one cycle after req -> mem_addr=0x1000, mem_be=1000, done with rdata=0x0000_0080, err=0.
REQ-036 Store H: addr=0x2002, wdata=0xDEAD_BEEF, ack after 3 wait cycles -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_req stable for 4 cycles, then done.
REQ-037 Load W at addr=0x3001 -> with LSU_MISALIGN_TRAP_EN: no mem_req, done+err at N+1; without: mem_addr=0x3000, be=1111, err=0.
REQ-038 Illegal case: funct3=011, then store with funct3=100 -> each gives done at N+1, err=1, rdata=0, and mem_req never rises.
REQ-039 Reset and back-to-back: rst_n low while mem_req=1 -> all outputs 0 at once, no done, and later ack ignored; start held in the DONE cycle ignored; next start accepted from IDLE.

Source files
------------

// File: rtl/lsu_rv32.sv
// RV32 load/store unit: one-outstanding data-bus access with byte/half/word lanes and load extension.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned H/W accesses into errors instead of truncating the address.
module lsu_rv32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      r_state;
  logic        r_busy, r_done, r_err, r_mem_req, r_mem_we, r_store;
  logic [31:0] r_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        w_illegal, w_misalign, w_err;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_lane, w_load;

  assign w_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && is_store);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_illegal || w_misalign;

  // Offsets are truncated to natural alignment; with trapping enabled legal accesses are already aligned.
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_off   = addr[1:0];
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_off   = {addr[1], 1'b0};
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  assign w_lane = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load = {24'd0, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load = {16'd0, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_store     <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy   <= 1'b1;
            r_store  <= is_store;
            r_funct3 <= funct3;
            r_off    <= w_off;
            if (w_err) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= 32'd0;
            end else begin
              r_state     <= REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= is_store;
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_err     <= 1'b0;
            r_rdata   <= r_store ? 32'd0 : w_load;
            r_mem_req <= 1'b0;
            r_mem_be  <= 4'd0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule
